key_event_arbiter: RTL and testbench
====================================

Name: key_event_arbiter

Overview:
- Collects debounced press/release pulses from NUM_KEYS key debouncer instances.
- Serialises them, in round-robin order, into one event stream with a valid/ready handshake and a small FIFO.
- Sits between the per-key debouncers and the single consumer, e.g. a UART reporter or menu FSM.
- Arbitrates the one consumer port among all keys; no event is lost silently.

Parameters:
NUM_KEYS, 4, number of keys; range 2..16.
ID_W, 2, width of key index; must equal ceil(log2(NUM_KEYS)).
FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
key_press  input  NUM_KEYS  one-cycle press pulse per key (bit i = key i).
key_release  input  NUM_KEYS  one-cycle release pulse per key.
evt_valid  output  1  FIFO head holds an event.
evt_ready  input  1  consumer accepts head when evt_valid && evt_ready.
evt_id  output  ID_W  key index of head event.
evt_type  output  1  1 = press, 0 = release.
evt_count  output  ID_W+1  FIFO occupancy, 0..FIFO_DEPTH.
overflow  output  1  one-cycle pulse: at least one pulse was merged into an already-pending one this cycle.

Behaviour:
- Reset (rst high at a clock edge):
  - all outputs 0, FIFO empty, all pending bits 0, round-robin pointer 0.
  - Pulses present in the reset cycle are discarded.
  - Reset mid-operation flushes the FIFO and all pending events.
- Pending capture: per key, two flags, pend_p[i] and pend_r[i].
  - A key_press[i] pulse sets pend_p[i] at the next edge; key_release[i] sets pend_r[i] the same way.
  - Pulse on a flag that is already set and not granted in that cycle: the flag stays set and overflow pulses high for one cycle (registered).
  - Pulse on a flag that is granted in the same cycle: the flag stays set, counts as a new event, no overflow.
- Grant: combinational selection, registered result, at most one grant per cycle.
  - Enabled only when evt_count < FIFO_DEPTH, using occupancy at the start of the cycle; a same-cycle pop does not enable a grant.
  - Key search starts at pointer ptr and wraps modulo NUM_KEYS. The first key with any pending flag wins.
  - Within the winning key: if pend_r is set and pend_p is clear, grant release; otherwise grant press.
  - After a grant to key k, ptr becomes (k+1) mod NUM_KEYS. With no grant, ptr holds.
  - The granted flag clears (subject to the re-set rule above), and {id=k, type} is written to the FIFO tail at the same edge.
- Latency: pulse at edge E0 sets pending; grant and write at E1; evt_valid high after E1. Minimum 2 cycles, pulse to evt_valid.
- FIFO: circular buffer with wrap-around read/write pointers and occupancy counter.
  - Pop happens when evt_valid && evt_ready.
  - Simultaneous push and pop leaves evt_count unchanged.
  - evt_id and evt_type show the head entry and stay stable while evt_valid && !evt_ready.
  - When empty, evt_valid=0 and evt_id/evt_type hold their last value (don't-care).
  - Full: grants stall and pulses stay pending; overflow fires only on the merge rule.
- Ordering: events of one key leave in grant order. Across keys, order follows the round-robin rule only.

Test Plan:
- Reset: drive pulses on all keys while rst=1, then release reset -> evt_valid=0, evt_count=0, overflow=0 for 10 cycles.
- Single event: key_press[2] at cycle 5, evt_ready=1 -> evt_valid high at cycle 7 with evt_id=2, evt_type=1, for 1 cycle; evt_count returns to 0.
- Fairness: press pulses on keys 0..3 in one cycle, evt_ready=1 -> ids 0,1,2,3 on consecutive cycles. Repeat with ptr=2 -> ids 2,3,0,1.
- Backpressure/full: evt_ready=0, then 6 events across 4 keys (FIFO_DEPTH=4) -> evt_count saturates at 4, 2 events stay pending, no overflow. Raise evt_ready -> all 6 delivered, head stable while stalled.
- Overflow: evt_ready=0, FIFO full, two key_press[1] pulses 3 cycles apart -> overflow high exactly 1 cycle; only one press for key 1 is delivered after drain.
- Same-cycle re-set: key_press[0] pulse in the exact cycle pend_p[0] is granted -> two press events for key 0 delivered, overflow stays 0.

Source files
------------

// File: rtl/key_event_if.sv
// key_event_if: key pulse inputs and serialised event stream between arbiter and consumer.
interface key_event_if #(
  parameter int NUM_KEYS = 4,
  parameter int ID_W     = 2
);
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                evt_valid;
  logic                evt_ready;
  logic [ID_W-1:0]     evt_id;
  logic                evt_type;
  logic [ID_W:0]       evt_count;
  logic                overflow;
  modport master (
    input  key_press, key_release, evt_ready,
    output evt_valid, evt_id, evt_type, evt_count, overflow
  );
  modport slave (
    output key_press, key_release, evt_ready,
    input  evt_valid, evt_id, evt_type, evt_count, overflow
  );
endinterface

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: round-robin serialiser of per-key press/release pulses into a FIFO'd event stream.
module key_event_arbiter #(
  parameter int NUM_KEYS   = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  key_event_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [NUM_KEYS-1:0] pend_p, pend_r, clr_p, clr_r;
  logic [ID_W-1:0]     ptr, gk, k;
  logic                found, gnt, gtype, pop, ovf;
  logic [ID_W:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [ID_W:0]       count;
  always_comb begin
    found = 1'b0;
    gk    = '0;
    k     = '0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      k = ID_W'((int'(ptr) + j) % NUM_KEYS);
      if (!found && (pend_p[k] || pend_r[k])) begin
        found = 1'b1;
        gk    = k;
      end
    end
  end
  // Grant uses occupancy at cycle start; a same-cycle pop does not free a slot.
  assign gnt   = found && (count < (ID_W+1)'(FIFO_DEPTH));
  assign gtype = !(pend_r[gk] && !pend_p[gk]);
  assign clr_p = (gnt && gtype)  ? NUM_KEYS'(1) << gk : '0;
  assign clr_r = (gnt && !gtype) ? NUM_KEYS'(1) << gk : '0;
  assign pop   = bus.evt_valid && bus.evt_ready;
  assign bus.evt_valid = count != '0;
  assign bus.evt_count = count;
  assign bus.overflow  = ovf;
  assign {bus.evt_id, bus.evt_type} = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p <= '0;
      pend_r <= '0;
      ptr    <= '0;
      ovf    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pend_p <= (pend_p & ~clr_p) | bus.key_press;
      pend_r <= (pend_r & ~clr_r) | bus.key_release;
      ovf    <= (|(bus.key_press & pend_p & ~clr_p)) || (|(bus.key_release & pend_r & ~clr_r));
      if (gnt) begin
        mem[wr_ptr] <= {gk, gtype};
        wr_ptr      <= wr_ptr + 1'b1;
        ptr         <= (gk == ID_W'(NUM_KEYS-1)) ? '0 : gk + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ID_W+1)'(gnt) - (ID_W+1)'(pop);
    end
  end
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed plus random stimulus against a queue-based event model.
module tb_key_event_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  key_event_if #(.NUM_KEYS(4), .ID_W(2)) bus();
  key_event_arbiter #(.NUM_KEYS(4), .ID_W(2), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit mp[4];
  bit mr[4];
  int mptr;
  int q[$];
  bit movf;
  task automatic model(input logic [3:0] p, input logic [3:0] r, input logic rdy, input logic rs);
    int g;
    bit gt;
    if (rs) begin
      foreach (mp[i]) begin mp[i] = 0; mr[i] = 0; end
      mptr = 0; q.delete(); movf = 0;
      return;
    end
    g = -1;
    gt = 0;
    if (q.size() < 4)
      for (int j = 0; j < 4; j++)
        if (g < 0 && (mp[(mptr + j) % 4] || mr[(mptr + j) % 4])) g = (mptr + j) % 4;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (g >= 0) begin
      gt = !(mr[g] && !mp[g]);
      q.push_back(g * 2 + int'(gt));
      if (gt) mp[g] = 0; else mr[g] = 0;
      mptr = (g + 1) % 4;
    end
    movf = 0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin if (mp[i]) movf = 1; mp[i] = 1; end
      if (r[i]) begin if (mr[i]) movf = 1; mr[i] = 1; end
    end
  endtask
  task automatic chk(input string name, input logic [7:0] got, input int exp);
    checks++;
    assert (got === 8'(exp)) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick(input logic [3:0] p, input logic [3:0] r, input logic rdy, input logic rs);
    rst = rs;
    bus.key_press = p;
    bus.key_release = r;
    bus.evt_ready = rdy;
    @(posedge clk);
    model(p, r, rdy, rs);
    #1;
    chk("evt_valid", 8'(bus.evt_valid), int'(q.size() != 0));
    chk("evt_count", 8'(bus.evt_count), q.size());
    chk("overflow", 8'(bus.overflow), int'(movf));
    if (q.size() != 0) begin
      chk("evt_id", 8'(bus.evt_id), q[0] / 2);
      chk("evt_type", 8'(bus.evt_type), q[0] % 2);
    end
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(4'h0, 4'h0, rdy, 1'b0);
  endtask
  initial begin
    tick(4'hF, 4'hF, 1'b1, 1'b1);
    tick(4'hF, 4'hF, 1'b1, 1'b1);
    idle(10, 1'b1);
    tick(4'b0100, 4'h0, 1'b1, 1'b0);
    chk("single_lat1_valid", 8'(bus.evt_valid), 0);
    tick(4'h0, 4'h0, 1'b1, 1'b0);
    chk("single_valid", 8'(bus.evt_valid), 1);
    chk("single_id", 8'(bus.evt_id), 2);
    chk("single_type", 8'(bus.evt_type), 1);
    idle(3, 1'b1);
    chk("single_drained", 8'(bus.evt_count), 0);
    tick(4'hF, 4'h0, 1'b1, 1'b0);
    idle(6, 1'b1);
    tick(4'b0010, 4'h0, 1'b1, 1'b0);
    idle(3, 1'b1);
    tick(4'hF, 4'h0, 1'b1, 1'b0);
    idle(6, 1'b1);
    tick(4'hF, 4'b0011, 1'b0, 1'b0);
    idle(8, 1'b0);
    chk("full_count", 8'(bus.evt_count), 4);
    idle(10, 1'b1);
    tick(4'hF, 4'h0, 1'b0, 1'b0);
    idle(5, 1'b0);
    tick(4'b0010, 4'h0, 1'b0, 1'b0);
    idle(2, 1'b0);
    tick(4'b0010, 4'h0, 1'b0, 1'b0);
    chk("ovf_pulse", 8'(bus.overflow), 1);
    idle(1, 1'b0);
    chk("ovf_once", 8'(bus.overflow), 0);
    idle(10, 1'b1);
    tick(4'b0001, 4'h0, 1'b1, 1'b0);
    tick(4'b0001, 4'h0, 1'b1, 1'b0);
    chk("reset_no_ovf", 8'(bus.overflow), 0);
    idle(6, 1'b1);
    for (int c = 0; c < 600; c++) begin
      logic [3:0] p;
      logic [3:0] r;
      p = 4'($urandom & $urandom & $urandom);
      r = 4'($urandom & $urandom & $urandom);
      tick(p, r, 1'($urandom_range(0, 3) != 0), 1'(c == 300));
    end
    idle(20, 1'b1);
    chk("final_empty", 8'(bus.evt_count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
